// File: rtl/wr_mem_noc_arb.sv
// wr_mem_noc_arb
//   Shares a single wr_mem_noc write path among NUM_SRCS requesters. One
//   request is in flight at a time: arbitrate, forward the request, pass the
//   granted source's data beats through, route the done handshake back, then
//   re-arbitrate. The granted source owns the path until its done handshake.
//
// Configuration macro:
//   WR_MEM_NOC_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                                 undefined -> round-robin (default)
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   src_wr_mem_req_val/_entry      per-source request (entry = flattened mem_req_struct)
//   wr_mem_src_req_rdy             per-source request accept
//   src_wr_mem_req_data_*          per-source data beat (val/data/last/padbytes)
//   wr_mem_src_req_data_rdy        per-source data accept
//   wr_req_done / wr_req_done_rdy  per-source completion handshake
//   arb_wr_mem_req_* / wr_mem_arb_req_rdy          downstream request
//   arb_wr_mem_req_data_* / wr_mem_arb_req_data_rdy downstream data beat
//   arb_wr_req_done / arb_wr_req_done_rdy          downstream completion
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; scan requests from rr_ptr_reg and latch a winner
// REQ   | granted request forwarded downstream, waiting for accept
// DATA  | granted data channel passed through until the last beat
// DONE  | downstream done routed to the granted source until accepted
module wr_mem_noc_arb #(
    parameter int NUM_SRCS           = 2,
    parameter int NOC_DATA_WIDTH     = 64,
    parameter int NOC_PADBYTES_WIDTH = 3,
    parameter int MEM_REQ_W          = 40
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_SRCS-1:0]                    src_wr_mem_req_val,
    input  logic [NUM_SRCS*MEM_REQ_W-1:0]          src_wr_mem_req_entry,
    output logic [NUM_SRCS-1:0]                    wr_mem_src_req_rdy,
    input  logic [NUM_SRCS-1:0]                    src_wr_mem_req_data_val,
    input  logic [NUM_SRCS*NOC_DATA_WIDTH-1:0]     src_wr_mem_req_data,
    input  logic [NUM_SRCS-1:0]                    src_wr_mem_req_data_last,
    input  logic [NUM_SRCS*NOC_PADBYTES_WIDTH-1:0] src_wr_mem_req_data_padbytes,
    output logic [NUM_SRCS-1:0]                    wr_mem_src_req_data_rdy,
    output logic [NUM_SRCS-1:0]                    wr_req_done,
    input  logic [NUM_SRCS-1:0]                    wr_req_done_rdy,
    output logic                                   arb_wr_mem_req_val,
    output logic [MEM_REQ_W-1:0]                   arb_wr_mem_req_entry,
    input  logic                                   wr_mem_arb_req_rdy,
    output logic                                   arb_wr_mem_req_data_val,
    output logic [NOC_DATA_WIDTH-1:0]              arb_wr_mem_req_data,
    output logic                                   arb_wr_mem_req_data_last,
    output logic [NOC_PADBYTES_WIDTH-1:0]          arb_wr_mem_req_data_padbytes,
    input  logic                                   wr_mem_arb_req_data_rdy,
    input  logic                                   arb_wr_req_done,
    output logic                                   arb_wr_req_done_rdy
);

    localparam int SRC_IDX_W = $clog2(NUM_SRCS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [SRC_IDX_W-1:0] grant_reg, grant_d;
    logic [SRC_IDX_W-1:0] rr_ptr_reg, rr_ptr_d;

    logic                 scan_found;
    logic [SRC_IDX_W-1:0] scan_idx;
    logic [SRC_IDX_W:0]   cand;

    // Circular scan starting at rr_ptr_reg. One extra bit on cand lets the
    // wrap be an explicit subtract, so non-power-of-2 NUM_SRCS works.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            cand = {1'b0, rr_ptr_reg} + (SRC_IDX_W+1)'(i);
            if (cand >= (SRC_IDX_W+1)'(NUM_SRCS)) begin
                cand = cand - (SRC_IDX_W+1)'(NUM_SRCS);
            end
            if (!scan_found && src_wr_mem_req_val[cand[SRC_IDX_W-1:0]]) begin
                scan_found = 1'b1;
                scan_idx   = cand[SRC_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d                      = state_q;
        grant_d                      = grant_reg;
        rr_ptr_d                     = rr_ptr_reg;
        wr_mem_src_req_rdy           = '0;
        wr_mem_src_req_data_rdy      = '0;
        wr_req_done                  = '0;
        arb_wr_mem_req_val           = 1'b0;
        arb_wr_mem_req_entry         = '0;
        arb_wr_mem_req_data_val      = 1'b0;
        arb_wr_mem_req_data          = '0;
        arb_wr_mem_req_data_last     = 1'b0;
        arb_wr_mem_req_data_padbytes = '0;
        arb_wr_req_done_rdy          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (scan_found) begin
                    grant_d = scan_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                arb_wr_mem_req_val            = src_wr_mem_req_val[grant_reg];
                arb_wr_mem_req_entry          = src_wr_mem_req_entry[grant_reg*MEM_REQ_W +: MEM_REQ_W];
                wr_mem_src_req_rdy[grant_reg] = wr_mem_arb_req_rdy;
                // A source withdrawing its request abandons the grant; the
                // pointer is left alone so it is not penalised.
                if (!src_wr_mem_req_val[grant_reg]) begin
                    state_d = ST_IDLE;
                end else if (wr_mem_arb_req_rdy) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                arb_wr_mem_req_data_val            = src_wr_mem_req_data_val[grant_reg];
                arb_wr_mem_req_data                = src_wr_mem_req_data[grant_reg*NOC_DATA_WIDTH +: NOC_DATA_WIDTH];
                arb_wr_mem_req_data_last           = src_wr_mem_req_data_last[grant_reg];
                arb_wr_mem_req_data_padbytes       = src_wr_mem_req_data_padbytes[grant_reg*NOC_PADBYTES_WIDTH +: NOC_PADBYTES_WIDTH];
                wr_mem_src_req_data_rdy[grant_reg] = wr_mem_arb_req_data_rdy;
                if (src_wr_mem_req_data_val[grant_reg] && wr_mem_arb_req_data_rdy
                    && src_wr_mem_req_data_last[grant_reg]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                wr_req_done[grant_reg] = arb_wr_req_done;
                arb_wr_req_done_rdy    = wr_req_done_rdy[grant_reg];
                if (arb_wr_req_done && wr_req_done_rdy[grant_reg]) begin
`ifdef WR_MEM_NOC_ARB_FIXED_PRIO_EN
                    rr_ptr_d = '0;
`else
                    rr_ptr_d = (grant_reg == SRC_IDX_W'(NUM_SRCS-1)) ? '0
                                                                     : grant_reg + SRC_IDX_W'(1);
`endif
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_q    <= state_d;
            grant_reg  <= grant_d;
            rr_ptr_reg <= rr_ptr_d;
        end
    end

endmodule
